// File: rtl/pulse_out_pio.sv
// rtl/pulse_out_pio.sv - Avalon-MM output PIO with atomic set/clear and a hardware toggle-pulse engine
module pulse_out_pio #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             busy
);

    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_PULSE_LEN = 3'd1;
    localparam logic [2:0] A_OUTSET   = 3'd2;
    localparam logic [2:0] A_OUTCLEAR = 3'd3;
    localparam logic [2:0] A_PULSE    = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;

    typedef enum logic {S_IDLE, S_PULSE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               overrun_q, overrun_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [WIDTH-1:0]   out_q, out_d;

    logic               wr;
    logic [WIDTH-1:0]   wr_mask;
    logic               unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wr_mask   = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        len_d     = len_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        rdata_d   = '0;

        if (wr) begin
            case (address)
                A_DATA:      data_d = wr_mask;
                A_PULSE_LEN: len_d  = writedata[CNT_W-1:0];
                A_OUTSET:    data_d = data_q | wr_mask;
                A_OUTCLEAR:  data_d = data_q & ~wr_mask;
                A_STATUS:    if (writedata[1]) overrun_d = 1'b0;
                default: ;
            endcase
        end

        // The return-to-IDLE edge still counts as busy for a colliding PULSE write.
        case (state_q)
            S_IDLE: begin
                if (wr && address == A_PULSE && wr_mask != '0 && len_q != '0) begin
                    state_d = S_PULSE;
                    mask_d  = wr_mask;
                    cnt_d   = len_q;
                end
            end
            S_PULSE: begin
                if (wr && address == A_PULSE) overrun_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    mask_d  = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (address)
            A_DATA:      rdata_d[WIDTH-1:0] = data_q;
            A_PULSE_LEN: rdata_d[CNT_W-1:0] = len_q;
            A_PULSE:     rdata_d[WIDTH-1:0] = mask_q;
            A_STATUS:    rdata_d[1:0]       = {overrun_q, state_q == S_PULSE};
            default: ;
        endcase

        out_d = data_q ^ mask_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            len_q     <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            rdata_q   <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            len_q     <= len_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            rdata_q   <= rdata_d;
            out_q     <= out_d;
        end
    end

    assign readdata = rdata_q;
    assign out_port = out_q;
    assign busy     = (state_q == S_PULSE);

endmodule

// File: tb/tb_pulse_out_pio.sv
// tb/tb_pulse_out_pio.sv - directed self-checking bench for pulse_out_pio
module tb_pulse_out_pio;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        busy;

    int checks;
    int failures;

    pulse_out_pio #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        v          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        checks++;
        if (out_port !== 8'h00 || busy !== 1'b0 || readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_init out=%h busy=%b rd=%h exp 00/0/0", out_port, busy, readdata);
        end
        wr(3'd1, 32'd10);
        wr(3'd4, 32'h01);
        tick();
        checks++;
        if (out_port !== 8'h01 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_prepulse out=%h busy=%b exp 01/1", out_port, busy);
        end
        rd(3'd1, v);
        checks++;
        if (v !== 32'd10) begin
            failures++;
            $display("FAIL reset_len_rd got=%h exp=%h", v, 32'd10);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== 8'h00 || busy !== 1'b0 || readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_async out=%h busy=%b rd=%h exp 00/0/0", out_port, busy, readdata);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        rd(3'd0, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", v); end
        rd(3'd1, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_len got=%h exp=0", v); end
        rd(3'd5, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", v); end
    endtask

    task automatic test_set_clear();
        logic [31:0] v;
        wr(3'd0, 32'hFFFF_FF0F);
        wr(3'd2, 32'h30);
        wr(3'd3, 32'h03);
        checks++;
        if (out_port !== 8'h3F) begin
            failures++;
            $display("FAIL setclr_latency got=%h exp=3f", out_port);
        end
        tick();
        checks++;
        if (out_port !== 8'h3C) begin
            failures++;
            $display("FAIL setclr_out got=%h exp=3c", out_port);
        end
        rd(3'd0, v);
        checks++;
        if (v !== 32'h3C) begin failures++; $display("FAIL setclr_data got=%h exp=3c", v); end
        rd(3'd2, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL setclr_outset_rd got=%h exp=0", v); end
    endtask

    task automatic test_pulse_len();
        wr(3'd1, 32'd5);
        wr(3'd0, 32'h80);
        tick();
        wr(3'd4, 32'h81);
        checks++;
        if (busy !== 1'b1 || out_port !== 8'h80) begin
            failures++;
            $display("FAIL pulse_start busy=%b out=%h exp 1/80", busy, out_port);
        end
        address    = 3'd4;
        chipselect = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (out_port !== ((k <= 5) ? 8'h01 : 8'h80) || busy !== (k < 5)) begin
                failures++;
                $display("FAIL pulse_len k=%0d out=%h busy=%b exp %h/%b", k, out_port, busy,
                         (k <= 5) ? 8'h01 : 8'h80, (k < 5));
            end
            if (k == 1) begin
                checks++;
                if (readdata !== 32'h81) begin
                    failures++;
                    $display("FAIL pulse_mask_rd got=%h exp=81", readdata);
                end
            end
        end
        chipselect = 1'b0;
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        wr(3'd0, 32'h00);
        wr(3'd1, 32'd10);
        wr(3'd4, 32'h02);
        tick();
        tick();
        wr(3'd4, 32'h04);
        rd(3'd5, v);
        checks++;
        if (v !== 32'h3) begin failures++; $display("FAIL overrun_busy_status got=%h exp=3", v); end
        for (int k = 5; k <= 11; k++) begin
            tick();
            checks++;
            if (out_port !== ((k <= 10) ? 8'h02 : 8'h00) || busy !== (k < 10)) begin
                failures++;
                $display("FAIL overrun_len k=%0d out=%h busy=%b exp %h/%b", k, out_port, busy,
                         (k <= 10) ? 8'h02 : 8'h00, (k < 10));
            end
        end
        rd(3'd5, v);
        checks++;
        if (v !== 32'h2) begin failures++; $display("FAIL overrun_sticky got=%h exp=2", v); end
        wr(3'd5, 32'h2);
        rd(3'd5, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL overrun_clear got=%h exp=0", v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        wr(3'd1, 32'd2);
        wr(3'd4, 32'h01);
        tick();
        wr(3'd4, 32'h01);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_restart busy=%b exp=0", busy); end
        rd(3'd5, v);
        checks++;
        if (v !== 32'h2 || out_port !== 8'h00) begin
            failures++;
            $display("FAIL b2b_edge status=%h out=%h exp 2/00", v, out_port);
        end
        wr(3'd5, 32'h2);
    endtask

    task automatic test_ignored();
        logic [31:0] v;
        wr(3'd0, 32'h55);
        wr(3'd1, 32'd4);
        wr(3'd4, 32'h00);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ign_mask0 busy=%b exp=0", busy); end
        wr(3'd1, 32'd0);
        wr(3'd4, 32'hFF);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ign_len0 busy=%b exp=0", busy); end
        tick();
        checks++;
        if (out_port !== 8'h55) begin failures++; $display("FAIL ign_out got=%h exp=55", out_port); end
        rd(3'd5, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL ign_status got=%h exp=0", v); end
    endtask

    task automatic test_data_during_pulse();
        wr(3'd0, 32'h00);
        wr(3'd1, 32'd6);
        wr(3'd4, 32'h01);
        tick();
        checks++;
        if (out_port !== 8'h01) begin failures++; $display("FAIL ddp_k1 got=%h exp=01", out_port); end
        wr(3'd0, 32'h01);
        checks++;
        if (out_port !== 8'h01) begin failures++; $display("FAIL ddp_k2 got=%h exp=01", out_port); end
        for (int k = 3; k <= 7; k++) begin
            tick();
            checks++;
            if (out_port !== ((k <= 6) ? 8'h00 : 8'h01)) begin
                failures++;
                $display("FAIL ddp k=%0d got=%h exp=%h", k, out_port, (k <= 6) ? 8'h00 : 8'h01);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        test_reset();
        test_set_clear();
        test_pulse_len();
        test_overrun();
        test_back_to_back();
        test_ignored();
        test_data_during_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
